// File: rtl/quad_position_speed_if.sv
// Control inputs and measurement outputs of the position/speed block.
// The master modport drives step/control signals; the slave modport is the block itself.
interface quad_position_speed_if #(
    parameter int POS_WIDTH    = 32,
    parameter int SPEED_WIDTH  = 16,
    parameter int WINDOW_WIDTH = 24,
    parameter int PERIOD_WIDTH = 24
);
    logic [WINDOW_WIDTH-1:0] window;
    logic                    pos_load;
    logic [POS_WIDTH-1:0]    pos_load_value;
    logic                    pulse;
    logic                    direction;
    logic [POS_WIDTH-1:0]    position;
    logic [SPEED_WIDTH-1:0]  speed;
    logic                    speed_valid;
    logic [PERIOD_WIDTH-1:0] period;
    logic                    period_valid;
    logic                    stalled;

    modport master (
        output window, pos_load, pos_load_value, pulse, direction,
        input  position, speed, speed_valid, period, period_valid, stalled
    );

    modport slave (
        input  window, pos_load, pos_load_value, pulse, direction,
        output position, speed, speed_valid, period, period_valid, stalled
    );
endinterface

// File: rtl/quad_position_speed.sv
// Position counter, windowed speed measurement and step-period/stall detection
// driven by a filtered pulse/direction step stream.
module quad_position_speed #(
    parameter int POS_WIDTH    = 32,
    parameter int SPEED_WIDTH  = 16,
    parameter int WINDOW_WIDTH = 24,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                  clock,
    input  logic                  arst_n,
    quad_position_speed_if.slave  bus
);
    // Symmetric clamp: the most negative code is never produced.
    localparam logic signed [SPEED_WIDTH:0] SAT_HI = $signed({2'b00, {(SPEED_WIDTH-1){1'b1}}});
    localparam logic signed [SPEED_WIDTH:0] SAT_LO = -SAT_HI;
    localparam logic [PERIOD_WIDTH-1:0]     PCNT_MAX = '1;

    logic signed [1:0]          step_val;
    logic [POS_WIDTH-1:0]       position_reg, position_next;
    logic [SPEED_WIDTH-1:0]     acc_reg, acc_next;
    logic [SPEED_WIDTH-1:0]     speed_reg, speed_next;
    logic                       speed_valid_reg, speed_valid_next;
    logic [WINDOW_WIDTH-1:0]    wcnt_reg, wcnt_next;
    logic signed [SPEED_WIDTH:0] acc_sum, acc_sat;
    logic [PERIOD_WIDTH-1:0]    pcnt_reg, pcnt_next;
    logic [PERIOD_WIDTH-1:0]    period_reg, period_next;
    logic                       period_valid_reg, period_valid_next;
    logic                       armed_reg, armed_next;
    logic                       stalled_reg, stalled_next;

    always_comb begin
        step_val = 2'sd0;
        if (bus.pulse) begin
            step_val = bus.direction ? -2'sd1 : 2'sd1;
        end

        position_next = bus.pos_load ? bus.pos_load_value
                      : position_reg + {{(POS_WIDTH-2){step_val[1]}}, step_val};

        acc_sum = {acc_reg[SPEED_WIDTH-1], acc_reg} + {{(SPEED_WIDTH-1){step_val[1]}}, step_val};
        if (acc_sum > SAT_HI) begin
            acc_sat = SAT_HI;
        end else if (acc_sum < SAT_LO) begin
            acc_sat = SAT_LO;
        end else begin
            acc_sat = acc_sum;
        end

        speed_next       = speed_reg;
        speed_valid_next = 1'b0;
        acc_next         = acc_sat[SPEED_WIDTH-1:0];
        wcnt_next        = wcnt_reg + WINDOW_WIDTH'(1);
        // >= rather than == so a window shortened below wcnt closes immediately
        if (wcnt_reg >= bus.window) begin
            speed_next       = acc_sat[SPEED_WIDTH-1:0];
            speed_valid_next = 1'b1;
            acc_next         = '0;
            wcnt_next        = '0;
        end

        period_next       = period_reg;
        period_valid_next = 1'b0;
        armed_next        = armed_reg;
        if (bus.pulse) begin
            pcnt_next  = '0;
            armed_next = 1'b1;
            if (armed_reg) begin
                period_next       = (pcnt_reg == PCNT_MAX) ? PCNT_MAX : pcnt_reg + PERIOD_WIDTH'(1);
                period_valid_next = 1'b1;
            end
        end else begin
            pcnt_next = (pcnt_reg == PCNT_MAX) ? pcnt_reg : pcnt_reg + PERIOD_WIDTH'(1);
        end

        // Derived from next-state values so stall clears together with the period strobe.
        stalled_next = armed_next && (pcnt_next == PCNT_MAX);
    end

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            position_reg     <= '0;
            acc_reg          <= '0;
            speed_reg        <= '0;
            speed_valid_reg  <= 1'b0;
            wcnt_reg         <= '0;
            pcnt_reg         <= '0;
            period_reg       <= '0;
            period_valid_reg <= 1'b0;
            armed_reg        <= 1'b0;
            stalled_reg      <= 1'b0;
        end else begin
            position_reg     <= position_next;
            acc_reg          <= acc_next;
            speed_reg        <= speed_next;
            speed_valid_reg  <= speed_valid_next;
            wcnt_reg         <= wcnt_next;
            pcnt_reg         <= pcnt_next;
            period_reg       <= period_next;
            period_valid_reg <= period_valid_next;
            armed_reg        <= armed_next;
            stalled_reg      <= stalled_next;
        end
    end

    assign bus.position     = position_reg;
    assign bus.speed        = speed_reg;
    assign bus.speed_valid  = speed_valid_reg;
    assign bus.period       = period_reg;
    assign bus.period_valid = period_valid_reg;
    assign bus.stalled      = stalled_reg;
endmodule
